// File: rtl/dilithium_input_framer.sv
// -----------------------------------------------------------------------------
// dilithium_input_framer
//
// Upstream feeder for the Dilithium core input stream. A host/DMA 64-bit
// stream (with a last flag) is buffered in a small first-word-fall-through
// FIFO. Each operation then delivers exactly frame_words words to the core:
// short host frames are padded with zero words, surplus words of long frames
// are accepted and dropped, and any length mismatch raises a sticky len_err.
// A malformed host frame therefore cannot hang or desynchronise the core.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle strobe, begins a frame (honoured only when idle)
//   frame_words  expected word count, sampled on an accepted start
//   s_valid/s_ready/s_data/s_last   host stream in
//   m_valid/m_ready/m_data          core stream out
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse when the frame is complete
//   len_err      sticky length-mismatch flag, cleared by the next start
// -----------------------------------------------------------------------------
module dilithium_input_framer #(
  parameter int DEPTH = 4,   // FIFO depth, power of two, >= 2
  parameter int LEN_W = 16   // frame word counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_words,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             busy,
  output logic             done,
  output logic             len_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, PAD, DRAIN, FLUSH} state_t;

  state_t state, state_nxt;

  // FIFO storage and bookkeeping
  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fill;
  logic             full, empty;
  logic             push, pop;
  logic [63:0]      push_data;

  // Frame bookkeeping
  logic [LEN_W-1:0] len_q, cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept;
  logic             last_of_len;
  logic             start_ok;

  assign full        = (fill == CNT_W'(DEPTH));
  assign empty       = (fill == '0);
  assign accept      = s_valid && s_ready;
  assign cnt_inc     = cnt + LEN_W'(1);
  assign last_of_len = (cnt_inc == len_q);
  assign start_ok    = (state == IDLE) && start;

  // First-word-fall-through read side; m_data is forced to zero while empty
  // so the output is defined (and zero) out of reset.
  assign m_valid = !empty;
  assign m_data  = empty ? 64'h0 : mem[rd_ptr];
  assign pop     = m_valid && m_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (frame_words == '0) ? FLUSH : LOAD;
      end
      LOAD: begin
        if (accept) begin
          if (last_of_len) state_nxt = s_last ? FLUSH : DRAIN;
          else if (s_last) state_nxt = PAD;
        end
      end
      PAD: begin
        if (push && last_of_len) state_nxt = FLUSH;
      end
      DRAIN: begin
        if (accept && s_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. s_ready is a function of state and FIFO fill only, never of
  // s_valid; a pop in the same cycle does not free a slot for the host.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready   = 1'b0;
    push      = 1'b0;
    push_data = 64'h0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        s_ready   = !full;
        push      = s_valid && !full;
        push_data = s_data;
      end
      PAD:     push    = !full;
      DRAIN:   s_ready = 1'b1;
      FLUSH:   done    = empty;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame length tracking. cnt only advances on pushes, and LOAD/PAD leave as
  // soon as cnt+1 reaches len_q, so cnt never passes len_q.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else if (start_ok) begin
      len_q   <= frame_words;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      if (push) cnt <= cnt_inc;
      // Mismatch: length reached without last, or last before length.
      if (state == LOAD && accept && (last_of_len != s_last)) len_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and fill count; DEPTH is a power of two so the pointers
  // wrap naturally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fill <= fill + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through m_data once fill marks an entry valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_dilithium_input_framer.sv
// -----------------------------------------------------------------------------
// tb_dilithium_input_framer
//
// Drives framed host traffic with random valid/ready patterns and compares the
// word stream seen by the core against a frame-level model: the core must see
// exactly frame_words words, the first min(frame_words, host_len) taken from
// the host, the rest zero, and len_err must equal (host_len != frame_words).
// -----------------------------------------------------------------------------
module tb_dilithium_input_framer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] frame_words;
  logic             s_valid;
  logic             s_ready;
  logic [63:0]      s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [63:0]      m_data;
  logic             busy;
  logic             done;
  logic             len_err;

  int n_vec = 0;
  int n_err = 0;

  dilithium_input_framer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_words (frame_words),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .done        (done),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one frame. All sampling and driving happens on the falling edge;
  // DUT outputs seen there hold until the next rising edge, and s_ready /
  // m_valid do not depend on the inputs driven in the same cycle.
  //   base         : nonzero -> host words are base, base+1, ...; 0 -> random
  //   stall        : m_ready held low for this many cycles first
  //   inj_start    : pulse a conflicting start while the frame is busy
  task automatic run_frame(input int len, input int n, input int vprob,
                           input int rprob, input int stall, input bit inj_start,
                           input logic [63:0] base,
                           output int acc_at_stall, output bit sready_at_stall);
    logic [63:0] host[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int  hi       = 0;
    int  done_cnt = 0;
    int  done_at  = -1;
    bit  zero_viol = 1'b0;
    bit  exp_err;

    acc_at_stall    = 0;
    sready_at_stall = 1'b0;

    for (int i = 0; i < n; i++)
      host.push_back(base != 0 ? base + 64'(i) : {$urandom, $urandom});
    for (int i = 0; i < len; i++)
      exp_q.push_back(i < n ? host[i] : 64'h0);
    exp_err = (len != 0) && (n != len);

    @(negedge clk);
    start = 1'b1; frame_words = LEN_W'(len);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == stall) begin
        acc_at_stall    = hi;
        sready_at_stall = s_ready;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (len == 0 && (s_ready || m_valid)) zero_viol = 1'b1;

      // core side
      m_ready = (cyc >= stall) && ($urandom_range(99) < rprob);
      if (m_valid && m_ready) got_q.push_back(m_data);

      // host side
      if (hi < n && $urandom_range(99) < vprob) begin
        s_valid = 1'b1; s_data = host[hi]; s_last = (hi == n - 1);
      end else begin
        s_valid = 1'b0; s_data = 64'h0; s_last = 1'b0;
      end
      if (s_valid && s_ready) hi++;

      // a start while busy must be ignored
      start       = inj_start && (cyc == 3) && busy;
      frame_words = start ? LEN_W'(len + 5) : LEN_W'(len);

      @(negedge clk);
      if (done_at >= 0 && cyc >= done_at + 3) break;
    end
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;

    check("frame_finished", 64'(done_at >= 0), 64'd1);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("word_count", 64'(got_q.size()), 64'(len));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("word[%0d]", i), i < got_q.size() ? got_q[i] : 64'hx, exp_q[i]);
    check("len_err", 64'(len_err), 64'(exp_err));
    check("host_consumed", 64'(hi), 64'(n));
    check("busy_after", 64'(busy), 64'd0);
    if (len == 0) begin
      check("zero_quiet", 64'(zero_viol), 64'd0);
      check("zero_done_latency", 64'(done_at >= 0 && done_at <= 1), 64'd1);
    end
  endtask

  int acc;
  bit srdy;

  initial begin
    rst = 1'b0; start = 1'b0; frame_words = '0;
    s_valid = 1'b0; s_data = 64'h0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_m_data",  m_data,       64'h0);
    rst = 1'b1;
    @(negedge clk);

    // nominal frame A0..A3
    run_frame(4, 4, 100, 100, 0, 1'b0, 64'hA0, acc, srdy);

    // backpressure: FIFO fills after DEPTH accepts, then everything drains
    run_frame(8, 8, 100, 100, 10, 1'b0, 64'h100, acc, srdy);
    check("bp_accepts", 64'(acc), 64'(DEPTH));
    check("bp_s_ready", 64'(srdy), 64'd0);

    // short frame: 3 of 6, zero padded
    run_frame(6, 3, 100, 100, 0, 1'b0, 64'h200, acc, srdy);

    // long frame: 5 sent, 2 expected
    run_frame(2, 5, 100, 100, 0, 1'b0, 64'h300, acc, srdy);

    // zero length
    run_frame(0, 0, 100, 100, 0, 1'b0, 64'h0, acc, srdy);

    // start while busy is ignored
    run_frame(3, 3, 50, 50, 0, 1'b1, 64'h400, acc, srdy);

    // reset mid-frame
    @(negedge clk);
    start = 1'b1; frame_words = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 64'h500 + 64'(i); s_last = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("pre_rst_m_valid", 64'(m_valid), 64'd1);
    check("pre_rst_busy",    64'(busy),    64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_busy",    64'(busy),    64'd0);
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_m_data",  m_data,       64'h0);
    @(negedge clk);
    rst = 1'b1;
    run_frame(4, 4, 100, 100, 0, 1'b0, 64'h600, acc, srdy);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int len, n;
      len = $urandom_range(10);
      n   = (len == 0) ? 0 : $urandom_range(len + 3, 1);
      run_frame(len, n, $urandom_range(100, 30), $urandom_range(100, 30),
                $urandom_range(1) ? 0 : $urandom_range(8), 1'($urandom_range(1)),
                64'h0, acc, srdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
